// File: rtl/speed_controller.sv
// rtl/speed_controller.sv - debounced speed buttons and auto-ramp FSM producing a frame-aligned step_size
module speed_controller #(
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int RAMP_FRAMES     = 30,
  parameter int INIT_LEVEL      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       auto_en,
  input  logic       next_frame,
  output logic [2:0] step_size,
  output logic [2:0] level,
  output logic       ramp_active
);

  localparam int DB_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam int RP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_FRAMES - 1);
  localparam logic [RP_W-1:0] RP_LAST    = RP_W'(RAMP_FRAMES - 1);
  localparam logic [2:0]      INIT_LVL   = 3'(INIT_LEVEL);

  typedef enum logic [1:0] {MANUAL = 2'd0, RAMP_UP = 2'd1, RAMP_DOWN = 2'd2} state_t;

  // Bit order everywhere: [0] btn_up, [1] btn_down, [2] auto_en
  logic [2:0]      raw, sync1, sync2, db, db_d, rise_q;
  logic            auto_fall_q;
  logic [DB_W-1:0] db_cnt [3];

  assign raw = {auto_en, btn_down, btn_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      db          <= '0;
      db_d        <= '0;
      rise_q      <= '0;
      auto_fall_q <= 1'b0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      db_d        <= db;
      rise_q      <= db & ~db_d;
      auto_fall_q <= ~db[2] & db_d[2];
      if (next_frame) begin
        for (int i = 0; i < 3; i++) begin
          if (sync2[i] != db[i]) begin
            if (db_cnt[i] == DB_LAST) begin
              db[i]     <= ~db[i];
              db_cnt[i] <= '0;
            end else begin
              db_cnt[i] <= db_cnt[i] + 1'b1;
            end
          end else begin
            db_cnt[i] <= '0;
          end
        end
      end
    end
  end

  state_t          state, state_next;
  logic [2:0]      level_next;
  logic [RP_W-1:0] ramp_cnt, ramp_cnt_next;
  logic            up_ev, dn_ev, auto_rise, ramp_tick;

  assign up_ev     = rise_q[0];
  assign dn_ev     = rise_q[1];
  assign auto_rise = rise_q[2];
  assign ramp_tick = next_frame && (ramp_cnt == RP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MANUAL;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MANUAL:
        if (auto_rise) state_next = (level != 3'd7) ? RAMP_UP : RAMP_DOWN;
      RAMP_UP:
        if (auto_fall_q)                     state_next = MANUAL;
        else if (ramp_tick && level == 3'd6) state_next = RAMP_DOWN;
      RAMP_DOWN:
        if (auto_fall_q)                     state_next = MANUAL;
        else if (ramp_tick && level == 3'd1) state_next = RAMP_UP;
      default: state_next = MANUAL;
    endcase
  end

  // Entering a ramp takes priority over any button event in the same cycle
  always_comb begin
    level_next    = level;
    ramp_cnt_next = ramp_cnt;
    case (state)
      MANUAL: begin
        ramp_cnt_next = '0;
        if (!auto_rise && up_ev && !dn_ev && level != 3'd7)      level_next = level + 3'd1;
        else if (!auto_rise && dn_ev && !up_ev && level != 3'd0) level_next = level - 3'd1;
      end
      RAMP_UP, RAMP_DOWN: begin
        if (auto_fall_q) begin
          ramp_cnt_next = '0;
        end else if (ramp_tick) begin
          ramp_cnt_next = '0;
          level_next    = (state == RAMP_UP) ? level + 3'd1 : level - 3'd1;
        end else if (next_frame) begin
          ramp_cnt_next = ramp_cnt + 1'b1;
        end
      end
      default: ramp_cnt_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level       <= INIT_LVL;
      step_size   <= INIT_LVL;
      ramp_cnt    <= '0;
      ramp_active <= 1'b0;
    end else begin
      level       <= level_next;
      ramp_cnt    <= ramp_cnt_next;
      ramp_active <= (state != MANUAL);
      if (next_frame) step_size <= level;
    end
  end

endmodule

// File: tb/tb_speed_controller.sv
// tb/tb_speed_controller.sv - randomized bench for speed_controller against a frame-level reference model
module tb_speed_controller;

  localparam int DEB  = 3;
  localparam int RAMP = 4;
  localparam int INIT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, auto_en = 1'b0, next_frame = 1'b0;
  logic [2:0] step_size, level;
  logic       ramp_active;

  speed_controller #(.DEBOUNCE_FRAMES(DEB), .RAMP_FRAMES(RAMP), .INIT_LEVEL(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down), .auto_en(auto_en),
    .next_frame(next_frame), .step_size(step_size), .level(level), .ramp_active(ramp_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check_val(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference model: inputs [0]=up [1]=down [2]=auto; mode 0=manual, +1/-1 = ramp direction
  int m_s1 [3], m_s2 [3], m_db [3], m_cnt [3], m_rise_at [3];
  int m_fall_at, m_cyc = 0;
  int m_lvl, m_step, m_ra, m_mode, m_frames;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_cnt[i] = 0; m_rise_at[i] = -1;
    end
    m_fall_at = -1;
    m_lvl = INIT; m_step = INIT; m_ra = 0; m_mode = 0; m_frames = 0;
  endtask

  task automatic model_step();
    int raw [3];
    bit up, dn, ar, af;
    raw[0] = int'(btn_up); raw[1] = int'(btn_down); raw[2] = int'(auto_en);
    up = (m_rise_at[0] == m_cyc);
    dn = (m_rise_at[1] == m_cyc);
    ar = (m_rise_at[2] == m_cyc);
    af = (m_fall_at == m_cyc);
    if (next_frame) m_step = m_lvl;
    m_ra = (m_mode != 0);
    if (m_mode == 0) begin
      if (ar) begin
        m_mode = (m_lvl < 7) ? 1 : -1;
        m_frames = 0;
      end else if (up && !dn) m_lvl = (m_lvl < 7) ? m_lvl + 1 : 7;
      else if (dn && !up)     m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
    end else begin
      if (af) begin
        m_mode = 0;
        m_frames = 0;
      end else if (next_frame) begin
        m_frames++;
        if (m_frames == RAMP) begin
          m_frames = 0;
          m_lvl += m_mode;
          if (m_lvl == 7) m_mode = -1;
          else if (m_lvl == 0) m_mode = 1;
        end
      end
    end
    if (next_frame) begin
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB) begin
            m_db[i] = 1 - m_db[i];
            m_cnt[i] = 0;
            if (m_db[i] == 1) m_rise_at[i] = m_cyc + 2;
            else if (i == 2)  m_fall_at = m_cyc + 2;
          end
        end else m_cnt[i] = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
    m_cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("level", int'(level), m_lvl);
      check_val("step_size", int'(step_size), m_step);
      check_val("ramp_active", int'(ramp_active), m_ra);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int gap);
    next_frame = 1'b0;
    repeat (gap) tick();
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) frame(2);
  endtask

  task automatic press(input bit up, input bit dn);
    btn_up = up; btn_down = dn;
    frames(4);
    btn_up = 1'b0; btn_down = 1'b0;
    frames(4);
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("rst_level", int'(level), INIT);
    check_val("rst_step", int'(step_size), INIT);
    check_val("rst_ramp", int'(ramp_active), 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    check_val("por_level", int'(level), INIT);
    check_val("por_step", int'(step_size), INIT);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (10) tick();
    check_val("idle_level", int'(level), INIT);

    press(1'b1, 1'b0);
    check_val("up_once", int'(level), 3);

    btn_up = 1'b1;
    frames(2);
    btn_up = 1'b0;
    frames(4);
    check_val("short_press", int'(level), 3);

    repeat (6) press(1'b1, 1'b0);
    check_val("sat_top", int'(level), 7);

    press(1'b1, 1'b1);
    check_val("both_btn", int'(level), 7);

    press(1'b0, 1'b1);
    check_val("down_once", int'(level), 6);

    auto_en = 1'b1;
    frames(20);
    check_val("ramp_on", int'(ramp_active), 1);
    auto_en = 1'b0;
    frames(6);
    check_val("ramp_off", int'(ramp_active), 0);
    btn_up = 1'b1;
    frames(6);
    btn_up = 1'b0;
    frames(4);

    auto_en = 1'b1;
    frames(12);
    mid_reset();
    frames(2);
    check_val("requalify", int'(ramp_active), 0);
    frames(40);
    auto_en = 1'b0;
    frames(5);

    repeat (3) press(1'b0, 1'b1);
    frames(2);
    check_val("sat_bottom_path", int'(level), 0);
    press(1'b0, 1'b1);
    check_val("sat_bottom", int'(level), 0);

    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) == 0) btn_up = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) btn_down = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 20) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 250) == 0) mid_reset();
      frame($urandom_range(1, 5));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
